// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte-burst requesters, granting one burst at a time, round-robin.
// Define TX_ARB_FIXED_PRIORITY_EN to make the lowest requesting lane always win instead of rotating.
module uart_tx_arbiter #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_req,
    input  logic [8*N-1:0] i_byte,
    input  logic [N-1:0]   i_last,
    output logic [N-1:0]   o_ack,
    output logic [N-1:0]   o_grant,
    output logic           o_busy,
    output logic [7:0]     o_byte,
    output logic           o_byte_v,
    input  logic           i_tx_active,
    input  logic           i_tx_done
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, NEXT} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx, ptr_adv, start;
    logic [IW-1:0] gidx, gidx_nx, win_idx, cand;
    logic [N-1:0]  grant_nx;
    logic          win_found, last_q;
    logic [7:0]    lane_byte;

    always_comb begin
`ifdef TX_ARB_FIXED_PRIORITY_EN
        start   = '0;
        ptr_adv = '0;
`else
        start   = ptr;
        ptr_adv = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
`endif
    end

    // First requesting lane at or above start, wrapping past N-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(start) + k >= N) ? IW'(int'(start) + k - N) : IW'(int'(start) + k);
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        lane_byte = '0;
        for (int k = 0; k < N; k++) begin
            if (gidx == IW'(k)) lane_byte = i_byte[8*k +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gidx_nx  = gidx;
        grant_nx = o_grant;
        case (state)
            IDLE: begin
                if (win_found && !i_tx_active) begin
                    gidx_nx  = win_idx;
                    grant_nx = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    state_nx = LOAD;
                end
            end
            LOAD: state_nx = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        grant_nx = '0;
                        ptr_nx   = ptr_adv;
                        state_nx = IDLE;
                    end else begin
                        state_nx = NEXT;
                    end
                end
            end
            NEXT: begin
                // A dropped request mid-burst aborts the burst and releases the grant.
                if (i_req[gidx]) begin
                    state_nx = LOAD;
                end else begin
                    grant_nx = '0;
                    ptr_nx   = ptr_adv;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            o_grant  <= '0;
            last_q   <= 1'b0;
            o_byte   <= '0;
            o_byte_v <= 1'b0;
            o_ack    <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            gidx     <= gidx_nx;
            o_grant  <= grant_nx;
            o_byte_v <= (state == LOAD);
            o_ack    <= (state == LOAD) ? o_grant : '0;
            if (state == LOAD) begin
                o_byte <= lane_byte;
                last_q <= i_last[gidx];
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requester lanes, a burst-level reference model, and directed checks.
module tb_uart_tx_arbiter;
    localparam int N = 3;
`ifdef TX_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   i_req, i_last, o_ack, o_grant;
    logic [8*N-1:0] i_byte;
    logic           o_busy, o_byte_v, i_tx_active, i_tx_done;
    logic [7:0]     o_byte;
    int             n_chk = 0;
    int             n_err = 0;

    // Each lane entry is {last, byte}; the head is what the lane presents.
    logic [8:0] q0[$], q1[$], q2[$];

    uart_tx_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_byte(i_byte), .i_last(i_last),
        .o_ack(o_ack), .o_grant(o_grant), .o_busy(o_busy), .o_byte(o_byte),
        .o_byte_v(o_byte_v), .i_tx_active(i_tx_active), .i_tx_done(i_tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int lane, input logic last, input logic [7:0] b);
        case (lane)
            0: q0.push_back({last, b});
            1: q1.push_back({last, b});
            default: q2.push_back({last, b});
        endcase
    endtask

    task automatic clear_lanes();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic refresh();
        logic [8:0] h0, h1, h2;
        h0 = (q0.size() > 0) ? q0[0] : 9'h000;
        h1 = (q1.size() > 0) ? q1[0] : 9'h000;
        h2 = (q2.size() > 0) ? q2[0] : 9'h000;
        i_req  = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
        i_last = {h2[8], h1[8], h0[8]};
        i_byte = {h2[7:0], h1[7:0], h0[7:0]};
    endtask

    // Requesters: an acked byte is retired and the next one presented before the next edge.
    initial begin
        logic [N-1:0] ack_s;
        logic [8:0]   dump;
        refresh();
        forever begin
            @(posedge clk);
            ack_s = o_ack;
            #1;
            if (ack_s[0] && q0.size() > 0) dump = q0.pop_front();
            if (ack_s[1] && q1.size() > 0) dump = q1.pop_front();
            if (ack_s[2] && q2.size() > 0) dump = q2.pop_front();
            refresh();
            @(negedge clk);
            #1;
            refresh();
        end
    end

    // Reference model: tracks the burst owner and where each burst stands, one edge at a time.
    int         m_owner, m_ptr;
    bit         m_ok = 1'b0;
    bit         m_latch, m_wait, m_chk, m_last;
    logic [7:0] m_byte;
    logic       m_v;
    logic [N-1:0] m_ack;

    function automatic int pick(input logic [N-1:0] req, input int p);
        int s;
        s = FIXED ? 0 : p;
        for (int k = 0; k < N; k++) begin
            if (req[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        m_v   = 1'b0;
        m_ack = '0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_byte = 8'h00;
            m_latch = 0; m_wait = 0; m_chk = 0; m_last = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (m_owner < 0) begin
                if (!i_tx_active) m_owner = pick(i_req, m_ptr);
                m_latch = (m_owner >= 0);
            end else if (m_latch) begin
                m_byte = i_byte[8*m_owner +: 8];
                m_last = i_last[m_owner];
                m_v = 1'b1;
                m_ack[m_owner] = 1'b1;
                m_latch = 0;
                m_wait = 1;
            end else if (m_wait) begin
                if (i_tx_done) begin
                    m_wait = 0;
                    if (m_last) begin
                        m_ptr = FIXED ? 0 : (m_owner + 1) % N;
                        m_owner = -1;
                    end else begin
                        m_chk = 1;
                    end
                end
            end else if (m_chk) begin
                m_chk = 0;
                if (i_req[m_owner]) begin
                    m_latch = 1;
                end else begin
                    m_ptr = FIXED ? 0 : (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (m_ok) begin
            eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            n_chk++;
            if ({o_grant, o_busy, o_byte, o_byte_v, o_ack} !== {eg, m_owner >= 0, m_byte, m_v, m_ack}) begin
                n_err++;
                $display("FAIL model t=%0t: grant=%b/%b busy=%b/%b byte=%h/%h v=%b/%b ack=%b/%b",
                         $time, o_grant, eg, o_busy, m_owner >= 0, o_byte, m_byte, o_byte_v, m_v, o_ack, m_ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_done();
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_byte_v) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int seen_v;
        logic [7:0] burst [3];
        burst[0] = 8'h1B; burst[1] = 8'h5B; burst[2] = 8'h48;
        i_tx_active = 1'b0;
        i_tx_done   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {o_grant, o_busy, o_byte, o_byte_v, o_ack}, '0);

        // Single byte on lane 1.
        tick(); push(1, 1'b1, 8'h41);
        @(negedge clk); chk("single_t_grant", o_grant, 3'b000);
        tick(); @(negedge clk); chk("single_t1_grant", o_grant, 3'b010);
        tick(); @(negedge clk);
        chk("single_t2_v", o_byte_v, 1'b1);
        chk("single_t2_byte", o_byte, 8'h41);
        chk("single_t2_ack", o_ack, 3'b010);
        repeat (2) tick();
        pulse_done();
        @(negedge clk); chk("single_release", {o_grant, o_busy}, 4'b0000);

        // Lanes 0 and 2 together: rotation pointer now at 2.
        tick(); push(0, 1'b1, 8'h50); push(2, 1'b1, 8'h52);
        wait_strobe("ptr2_strobe"); chk("ptr2_first", o_ack, FIXED ? 3'b001 : 3'b100);
        pulse_done();
        wait_strobe("ptr2_strobe2"); chk("ptr2_second", o_ack, FIXED ? 3'b100 : 3'b001);
        pulse_done();

        // Abort: lane 2 sends a non-final byte then drops its request.
        tick(); push(2, 1'b0, 8'h30);
        wait_strobe("abort_strobe"); chk("abort_byte", o_byte, 8'h30);
        repeat (2) tick();
        i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        @(negedge clk); chk("abort_next_grant", o_grant, 3'b100);
        @(negedge clk); chk("abort_idle_grant", {o_grant, o_busy}, 4'b0000);
        seen_v = 0;
        repeat (5) begin @(negedge clk); if (o_byte_v) seen_v++; end
        chk("abort_no_second_strobe", 32'(seen_v), 32'd0);

        // Lanes 0 and 1: pointer wrapped to 0 by the abort.
        tick(); push(0, 1'b1, 8'h60); push(1, 1'b1, 8'h61);
        wait_strobe("ptr0_strobe"); chk("ptr0_first", o_ack, 3'b001);
        pulse_done();
        wait_strobe("ptr0_strobe2"); chk("ptr0_second", o_ack, 3'b010);
        pulse_done();

        // UART busy blocks a grant; a stray done in IDLE changes nothing.
        tick(); i_tx_active = 1'b1; push(0, 1'b1, 8'h70);
        repeat (4) @(negedge clk);
        chk("busy_no_grant", o_grant, 3'b000);
        pulse_done();
        @(negedge clk);
        chk("spurious_done", {o_grant, o_busy, o_byte_v, o_byte}, {4'b0000, 1'b0, 8'h61});
        tick(); i_tx_active = 1'b0;
        wait_strobe("busy_strobe"); chk("busy_byte", o_byte, 8'h70);
        pulse_done();

        // Three-byte burst on lane 0 with done 10 cycles after each strobe.
        tick();
        push(0, 1'b0, 8'h1B); push(0, 1'b0, 8'h5B); push(0, 1'b1, 8'h48);
        for (int i = 0; i < 3; i++) begin
            wait_strobe("burst_strobe");
            chk("burst_byte", o_byte, burst[i]);
            chk("burst_grant", o_grant, 3'b001);
            repeat (10) tick();
            i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        end
        @(negedge clk); chk("burst_busy_fall", {o_busy, o_grant}, 4'b0000);

        // Continuous single-byte requests on all lanes from a fresh pointer.
        tick(); rst = 1'b1; clear_lanes();
        repeat (2) tick(); rst = 1'b0;
        for (int l = 0; l < N; l++) begin
            push(l, 1'b1, 8'hA0 + 8'(l)); push(l, 1'b1, 8'hB0 + 8'(l));
        end
        for (int i = 0; i < 6; i++) begin
            int g;
            wait_strobe("rr_strobe");
            g = -1;
            for (int k = 0; k < N; k++) if (o_ack[k]) g = k;
            chk("rr_order", 32'(g), FIXED ? 32'd0 : 32'(i % N));
            tick();
            if (i < 5) push(g, 1'b1, 8'hC0 + 8'(i));
            else clear_lanes();
            tick();
            i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        end

        // Reset mid-burst after lane 0 moved the pointer to 1.
        tick(); push(0, 1'b1, 8'h80);
        wait_strobe("rst_pre_strobe");
        pulse_done();
        tick(); push(1, 1'b0, 8'h81); push(1, 1'b1, 8'h82);
        wait_strobe("rst_burst_strobe"); chk("rst_burst_ack", o_ack, 3'b010);
        tick(); rst = 1'b1; clear_lanes();
        @(negedge clk);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {o_grant, o_busy, o_byte, o_byte_v, o_ack}, '0);
        pulse_done();
        @(negedge clk); chk("rst_late_done", {o_grant, o_busy}, 4'b0000);
        tick(); push(0, 1'b1, 8'h90); push(1, 1'b1, 8'h91);
        wait_strobe("rst_after_strobe"); chk("rst_after_lane0", o_ack, 3'b001);
        pulse_done();
        wait_strobe("rst_after_strobe2"); chk("rst_after_lane1", o_ack, 3'b010);
        pulse_done();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
